// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader
// Description : Streams bitstream words, LSB first, into a configuration
//               flip-flop chain. Controls fabric isolation and user reset
//               around the load, with starvation timeout and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                             prog_clk,
    input  logic                             prog_reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [WORD_W-1:0]                cfg_data,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    output logic                             ccff_head,
    output logic                             ccff_shift_en,
    output logic                             isol_n,
    output logic                             reset,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_count
);

    localparam int c_bc_w = $clog2(CHAIN_LEN + 1);
    localparam int c_bl_w = $clog2(WORD_W + 1);
    localparam int c_sc_w = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;
    localparam logic [1:0] c_st_error = 2'd3;

    localparam logic [c_bc_w-1:0] c_bc_last   = c_bc_w'(CHAIN_LEN - 1);
    localparam logic [c_bc_w-1:0] c_bc_one    = c_bc_w'(1);
    localparam logic [c_bl_w-1:0] c_bl_word   = c_bl_w'(WORD_W);
    localparam logic [c_bl_w-1:0] c_bl_one    = c_bl_w'(1);
    localparam logic [c_sc_w-1:0] c_sc_one    = c_sc_w'(1);
    localparam logic [c_sc_w-1:0] c_sc_lastok = c_sc_w'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [WORD_W-1:0] r_sreg;
    logic [c_bl_w-1:0] r_bits_left;
    logic [c_sc_w-1:0] r_stall_cnt;
    logic [c_bc_w-1:0] r_bit_count;

    logic w_in_load;
    logic w_shift;
    logic w_ready;
    logic w_accept;
    logic w_starve;
    logic w_last_bit;
    logic w_timeout;
    logic w_restart;

    // A word is either being shifted out or the loader is waiting for the next one.
    assign w_in_load  = (r_state == c_st_load);
    assign w_shift    = w_in_load && (r_bits_left != '0);
    assign w_ready    = w_in_load && (r_bits_left == '0);
    assign w_accept   = w_ready && cfg_valid;
    assign w_starve   = w_ready && !cfg_valid;
    assign w_last_bit = w_shift && (r_bit_count == c_bc_last);
    assign w_timeout  = w_starve && (r_stall_cnt == c_sc_lastok);
    assign w_restart  = !w_in_load && start;

    assign bit_count  = r_bit_count;

    // State register.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; abort overrides everything, including start.
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_load: begin
                    if (w_last_bit) begin
                        w_state_next = c_st_done;
                    end else if (w_timeout) begin
                        w_state_next = c_st_error;
                    end
                end
                default: begin
                    if (start) begin
                        w_state_next = c_st_load;
                    end
                end
            endcase
        end
    end

    // Word shifter, bit counters and starvation counter.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            r_sreg      <= '0;
            r_bits_left <= '0;
            r_stall_cnt <= '0;
            r_bit_count <= '0;
        end else if (abort || w_restart) begin
            r_sreg      <= '0;
            r_bits_left <= '0;
            r_stall_cnt <= '0;
            r_bit_count <= '0;
        end else if (w_shift) begin
            r_bit_count <= r_bit_count + c_bc_one;
            if (w_last_bit) begin
                // Chain is full: drop whatever is left of the current word.
                r_sreg      <= '0;
                r_bits_left <= '0;
            end else begin
                r_sreg      <= r_sreg >> 1;
                r_bits_left <= r_bits_left - c_bl_one;
            end
        end else if (w_accept) begin
            r_sreg      <= cfg_data;
            r_bits_left <= c_bl_word;
            r_stall_cnt <= '0;
        end else if (w_starve) begin
            r_stall_cnt <= r_stall_cnt + c_sc_one;
        end
    end

    // Output decode from state; fabric stays isolated and in reset unless DONE.
    always_comb begin
        cfg_ready     = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        isol_n        = 1'b0;
        reset         = 1'b1;
        busy          = 1'b0;
        done          = 1'b0;
        error         = 1'b0;
        case (r_state)
            c_st_load: begin
                busy          = 1'b1;
                cfg_ready     = w_ready;
                ccff_shift_en = w_shift;
                ccff_head     = r_sreg[0];
            end
            c_st_done: begin
                done   = 1'b1;
                isol_n = 1'b1;
                reset  = 1'b0;
            end
            c_st_error: begin
                error = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccff_chain_loader
// Description : Self-checking bench; two loaders (64-bit and 20-bit chains)
//               share stimulus and are compared every cycle against a
//               bit-queue behavioural model, plus literal scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    localparam int WORD_W  = 8;
    localparam int TIMEOUT = 255;
    localparam int CL0     = 64;
    localparam int CL1     = 20;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic              clk = 1'b0;
    logic              prog_reset;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [WORD_W-1:0] cfg_data = '0;

    logic w_rdy0, w_head0, w_sh0, w_iso0, w_rst0, w_busy0, w_done0, w_err0;
    logic w_rdy1, w_head1, w_sh1, w_iso1, w_rst1, w_busy1, w_done1, w_err1;
    logic [6:0] w_bc0;
    logic [4:0] w_bc1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ccff_chain_loader #(.CHAIN_LEN(CL0), .WORD_W(WORD_W), .TIMEOUT(TIMEOUT)) u_dut0 (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(w_rdy0),
        .ccff_head(w_head0), .ccff_shift_en(w_sh0), .isol_n(w_iso0), .reset(w_rst0),
        .busy(w_busy0), .done(w_done0), .error(w_err0), .bit_count(w_bc0)
    );

    ccff_chain_loader #(.CHAIN_LEN(CL1), .WORD_W(WORD_W), .TIMEOUT(TIMEOUT)) u_dut1 (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(w_rdy1),
        .ccff_head(w_head1), .ccff_shift_en(w_sh1), .isol_n(w_iso1), .reset(w_rst1),
        .busy(w_busy1), .done(w_done1), .error(w_err1), .bit_count(w_bc1)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=0x%0h expected=0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per chain: mode, bits already in the chain, the word being delivered and
    // how many of its bits are still pending, consecutive starved cycles.
    int          cl_tab[2]  = '{CL0, CL1};
    int          m_mode[2]  = '{M_IDLE, M_IDLE};
    int          m_cnt[2]   = '{0, 0};
    int          m_pend[2]  = '{0, 0};
    int          m_stall[2] = '{0, 0};
    logic [7:0]  m_word[2]  = '{8'h00, 8'h00};

    always @(posedge clk or negedge prog_reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!prog_reset || abort) begin
                m_mode[i]  <= M_IDLE;
                m_cnt[i]   <= 0;
                m_pend[i]  <= 0;
                m_stall[i] <= 0;
            end else if (m_mode[i] == M_LOAD) begin
                if (m_pend[i] > 0) begin
                    m_cnt[i] <= m_cnt[i] + 1;
                    if (m_cnt[i] + 1 == cl_tab[i]) begin
                        m_mode[i] <= M_DONE;
                        m_pend[i] <= 0;
                    end else begin
                        m_pend[i] <= m_pend[i] - 1;
                    end
                end else if (cfg_valid) begin
                    m_word[i]  <= cfg_data;
                    m_pend[i]  <= WORD_W;
                    m_stall[i] <= 0;
                end else begin
                    m_stall[i] <= m_stall[i] + 1;
                    if (m_stall[i] + 1 == TIMEOUT) m_mode[i] <= M_ERR;
                end
            end else if (start) begin
                m_mode[i]  <= M_LOAD;
                m_cnt[i]   <= 0;
                m_pend[i]  <= 0;
                m_stall[i] <= 0;
            end
        end
    end

    function automatic longint b2l(input logic b);
        return b ? 64'd1 : 64'd0;
    endfunction

    // Per-cycle comparison of both loaders against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic   ld, sh, hd;
            ld = (m_mode[i] == M_LOAD);
            sh = ld && (m_pend[i] > 0);
            hd = sh ? m_word[i][WORD_W - m_pend[i]] : 1'b0;
            if (i == 0) begin
                check("cmp_busy0",  b2l(w_busy0), b2l(ld));
                check("cmp_done0",  b2l(w_done0), b2l(m_mode[0] == M_DONE));
                check("cmp_err0",   b2l(w_err0),  b2l(m_mode[0] == M_ERR));
                check("cmp_isol0",  b2l(w_iso0),  b2l(m_mode[0] == M_DONE));
                check("cmp_rst0",   b2l(w_rst0),  b2l(m_mode[0] != M_DONE));
                check("cmp_rdy0",   b2l(w_rdy0),  b2l(ld && m_pend[0] == 0));
                check("cmp_shift0", b2l(w_sh0),   b2l(sh));
                check("cmp_head0",  b2l(w_head0), b2l(hd));
                check("cmp_bc0",    longint'(w_bc0), longint'(m_cnt[0]));
            end else begin
                check("cmp_busy1",  b2l(w_busy1), b2l(ld));
                check("cmp_done1",  b2l(w_done1), b2l(m_mode[1] == M_DONE));
                check("cmp_err1",   b2l(w_err1),  b2l(m_mode[1] == M_ERR));
                check("cmp_isol1",  b2l(w_iso1),  b2l(m_mode[1] == M_DONE));
                check("cmp_rst1",   b2l(w_rst1),  b2l(m_mode[1] != M_DONE));
                check("cmp_rdy1",   b2l(w_rdy1),  b2l(ld && m_pend[1] == 0));
                check("cmp_shift1", b2l(w_sh1),   b2l(sh));
                check("cmp_head1",  b2l(w_head1), b2l(hd));
                check("cmp_bc1",    longint'(w_bc1), longint'(m_cnt[1]));
            end
        end
    end

    // Capture of the serial stream as the chain sees it.
    logic [63:0] cap0 = '0;
    logic [19:0] cap1 = '0;
    int          shifts0 = 0;
    int          shifts1 = 0;
    always @(negedge clk) begin
        if (w_sh0) begin
            cap0[w_bc0[5:0]] <= w_head0;
            shifts0          <= shifts0 + 1;
        end
        if (w_sh1) begin
            cap1[w_bc1] <= w_head1;
            shifts1     <= shifts1 + 1;
        end
    end

    // Random words with random gaps until both chains are done.
    task automatic feed_random(input int bound);
        int n;
        n = 0;
        while (!(w_done0 && w_done1) && n < bound) begin
            cfg_valid = ($urandom_range(0, 3) != 0);
            cfg_data  = 8'($urandom);
            start     = w_busy0 && w_busy1 && ($urandom_range(0, 15) == 0);
            @(negedge clk);
            n++;
        end
        start     = 1'b0;
        cfg_valid = 1'b0;
        check("feed_reached_done", b2l(w_done0 && w_done1), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w, s0, s1;
        logic acc;

        // Asynchronous reset before any clock edge.
        prog_reset = 1'b1;
        #1 prog_reset = 1'b0;
        #2;
        check("rst_async_rdy",   b2l(w_rdy0), 0);
        check("rst_async_shift", b2l(w_sh0), 0);
        check("rst_async_isol",  b2l(w_iso0), 0);
        check("rst_async_reset", b2l(w_rst0), 1);
        check("rst_async_bc",    longint'(w_bc0), 0);

        // Eight words 0x01..0x08 back-to-back, start on first edge after reset.
        @(negedge clk);
        @(negedge clk);
        prog_reset = 1'b1;
        s0 = shifts0; s1 = shifts1;
        w = 1; cfg_data = 8'(w); cfg_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_start_busy", b2l(w_busy0), 1);
        n = 0;
        while (!w_done0 && n < 200) begin
            acc = w_rdy0;
            @(negedge clk);
            n++;
            if (acc) begin
                w++;
                cfg_data = 8'(w);
            end
        end
        cfg_valid = 1'b0;
        #1;
        check("c64_done_edge",  longint'(n), 72);
        check("c64_stream",     longint'(cap0), 64'h0807060504030201);
        check("c64_shifts",     longint'(shifts0 - s0), 64);
        check("c64_isol",       b2l(w_iso0), 1);
        check("c64_reset",      b2l(w_rst0), 0);
        check("c64_bc",         longint'(w_bc0), 64);
        check("c20_done",       b2l(w_done1), 1);
        check("c20_bc",         longint'(w_bc1), 20);
        check("c20_stream",     longint'(cap1), 20'h30201);
        check("c20_shifts",     longint'(shifts1 - s1), 20);
        check("c20_ready",      b2l(w_rdy1), 0);

        // Reconfiguration from DONE.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("reload_isol",  b2l(w_iso0), 0);
        check("reload_reset", b2l(w_rst0), 1);
        check("reload_busy",  b2l(w_busy1), 1);
        feed_random(3000);
        #1;
        check("reload_bc0", longint'(w_bc0), 64);
        check("reload_bc1", longint'(w_bc1), 20);

        // Starvation: 254 starved cycles are tolerated, the 255th errors.
        @(negedge clk);
        start = 1'b1; cfg_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (254) @(negedge clk);
        check("starve254_err", b2l(w_err0), 0);
        check("starve254_busy", b2l(w_busy1), 1);
        @(negedge clk);
        check("starve255_err0", b2l(w_err0), 1);
        check("starve255_err1", b2l(w_err1), 1);
        check("starve255_isol", b2l(w_iso0), 0);
        check("starve255_bc",   longint'(w_bc0), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (254) @(negedge clk);
        cfg_valid = 1'b1; cfg_data = 8'hA5;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("late_word_err",   b2l(w_err0), 0);
        check("late_word_shift", b2l(w_sh0), 1);
        check("late_word_head",  b2l(w_head0), 1);
        feed_random(3000);

        // Abort (with concurrent start) at bit_count 30.
        @(negedge clk);
        start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (w_bc0 != 7'd30 && n < 400) begin
            cfg_data = 8'($urandom);
            @(negedge clk);
            n++;
        end
        check("abort_reached_30", longint'(w_bc0), 30);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; cfg_valid = 1'b0;
        check("abort_busy",  b2l(w_busy0), 0);
        check("abort_shift", b2l(w_sh0), 0);
        check("abort_bc0",   longint'(w_bc0), 0);
        check("abort_done1", b2l(w_done1), 0);
        @(negedge clk);
        check("abort_stays_idle", b2l(w_busy0), 0);

        // Reset mid-word with five bits of the second word still pending.
        start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (w_bc0 != 7'd11 && n < 100) begin
            cfg_data = 8'($urandom);
            @(negedge clk);
            n++;
        end
        check("midword_shifting", b2l(w_sh0), 1);
        #2 prog_reset = 1'b0;
        #1;
        check("midrst_shift", b2l(w_sh0), 0);
        check("midrst_head",  b2l(w_head0), 0);
        check("midrst_busy",  b2l(w_busy0), 0);
        check("midrst_reset", b2l(w_rst0), 1);
        check("midrst_bc0",   longint'(w_bc0), 0);
        check("midrst_bc1",   longint'(w_bc1), 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        prog_reset = 1'b1;
        @(negedge clk);
        check("post_rst_shift", b2l(w_sh0), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed_random(3000);
        #1;
        check("post_rst_bc0", longint'(w_bc0), 64);
        check("post_rst_isol", b2l(w_iso0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
